// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver (uart_rx_cfg).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int UART_MIN_CPB = 8;

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the serial line followed by a 3-tap history
// whose majority gives a glitch-filtered bit.
module uart_rx_sync_vote (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Rx_Serial,
    output logic o_Sync_Bit,
    output logic o_Vote_Bit
);

    logic       meta_reg;
    logic       sync_reg;
    logic [2:0] tap_reg;

    // Line idles high, so every stage resets to 1 to avoid a false start bit.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            tap_reg  <= 3'b111;
        end else begin
            meta_reg <= i_Rx_Serial;
            sync_reg <= meta_reg;
            tap_reg  <= {tap_reg[1:0], sync_reg};
        end
    end

    assign o_Sync_Bit = sync_reg;
    assign o_Vote_Bit = (tap_reg[0] & tap_reg[1]) |
                        (tap_reg[0] & tap_reg[2]) |
                        (tap_reg[1] & tap_reg[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits. Define UART_RX_BREAK_DETECT_EN to enable break detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16,
    parameter int MIN_CPB   = UART_MIN_CPB
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Two_Stop,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy,
    output logic                 o_Break
);

    localparam int IDX_W = $clog2(DATA_BITS);

    logic rx_sync;
    logic rx_vote;

    uart_rx_sync_vote u_sync_vote (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Sync_Bit  (rx_sync),
        .o_Vote_Bit  (rx_vote)
    );

    rx_state_t            state_reg, state_next;
    logic [DIV_W-1:0]     cnt_reg, cnt_next;
    logic [DIV_W-1:0]     cpb_reg, cpb_next;
    logic [1:0]           par_mode_reg, par_mode_next;
    logic                 two_stop_reg, two_stop_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic                 stop_idx_reg, stop_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_bit_reg, par_bit_next;
    logic                 frame_acc_reg, frame_acc_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 perr_reg, perr_next;
    logic                 ferr_reg, ferr_next;
    logic                 dv_reg, dv_next;
    logic                 brk_reg, brk_next;

    logic [DIV_W-1:0]     cpb_clamped;
    logic [DIV_W-1:0]     half_cnt;
    logic [DIV_W-1:0]     last_cnt;
    logic                 par_en;
    logic                 par_xor;
    logic                 break_hit;
    logic [DATA_BITS-1:0] bit_sel;

    assign cpb_clamped = (i_Clks_Per_Bit < DIV_W'(MIN_CPB)) ? DIV_W'(MIN_CPB) : i_Clks_Per_Bit;
    assign last_cnt    = cpb_reg - DIV_W'(1);
    assign half_cnt    = last_cnt >> 1;
    assign par_en      = (par_mode_reg != PAR_NONE);
    assign par_xor     = ^{shift_reg, par_bit_reg};

    // One-hot write enable for the data bit currently being sampled.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (bit_idx_reg == IDX_W'(gi));
    end

`ifdef UART_RX_BREAK_DETECT_EN
    assign break_hit = ~stop_idx_reg & ~rx_vote & ~(|shift_reg) & ~(par_en & par_bit_reg);
`else
    assign break_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cpb_next       = cpb_reg;
        par_mode_next  = par_mode_reg;
        two_stop_next  = two_stop_reg;
        bit_idx_next   = bit_idx_reg;
        stop_idx_next  = stop_idx_reg;
        shift_next     = shift_reg;
        par_bit_next   = par_bit_reg;
        frame_acc_next = frame_acc_reg;
        data_next      = data_reg;
        perr_next      = perr_reg;
        ferr_next      = ferr_reg;
        dv_next        = 1'b0;
        brk_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_sync) begin
                    state_next     = START;
                    cnt_next       = '0;
                    cpb_next       = cpb_clamped;
                    par_mode_next  = (i_Parity_Mode == PAR_EVEN || i_Parity_Mode == PAR_ODD) ?
                                     i_Parity_Mode : PAR_NONE;
                    two_stop_next  = i_Two_Stop;
                    bit_idx_next   = '0;
                    stop_idx_next  = 1'b0;
                    shift_next     = '0;
                    par_bit_next   = 1'b0;
                    frame_acc_next = 1'b0;
                end
            end

            START: begin
                if (cnt_reg == half_cnt) begin
                    cnt_next   = '0;
                    state_next = rx_vote ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end

            DATA: begin
                if (cnt_reg == last_cnt) begin
                    cnt_next   = '0;
                    shift_next = (shift_reg & ~bit_sel) | (bit_sel & {DATA_BITS{rx_vote}});
                    if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end

            PARITY: begin
                if (cnt_reg == last_cnt) begin
                    cnt_next     = '0;
                    par_bit_next = rx_vote;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end

            STOP: begin
                if (cnt_reg == last_cnt) begin
                    cnt_next = '0;
                    if (break_hit) begin
                        brk_next   = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (stop_idx_reg == two_stop_reg) begin
                        dv_next    = 1'b1;
                        data_next  = shift_reg;
                        perr_next  = par_en & ((par_mode_reg == PAR_ODD) ? ~par_xor : par_xor);
                        ferr_next  = frame_acc_reg | ~rx_vote;
                        state_next = rx_vote ? IDLE : WAIT_HIGH;
                    end else begin
                        stop_idx_next  = 1'b1;
                        frame_acc_next = frame_acc_reg | ~rx_vote;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end

            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cpb_reg       <= '0;
            par_mode_reg  <= PAR_NONE;
            two_stop_reg  <= 1'b0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            shift_reg     <= '0;
            par_bit_reg   <= 1'b0;
            frame_acc_reg <= 1'b0;
            data_reg      <= '0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            dv_reg        <= 1'b0;
            brk_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cpb_reg       <= cpb_next;
            par_mode_reg  <= par_mode_next;
            two_stop_reg  <= two_stop_next;
            bit_idx_reg   <= bit_idx_next;
            stop_idx_reg  <= stop_idx_next;
            shift_reg     <= shift_next;
            par_bit_reg   <= par_bit_next;
            frame_acc_reg <= frame_acc_next;
            data_reg      <= data_next;
            perr_reg      <= perr_next;
            ferr_reg      <= ferr_next;
            dv_reg        <= dv_next;
            brk_reg       <= brk_next;
        end
    end

    assign o_Rx_DV      = dv_reg;
    assign o_Rx_Data    = data_reg;
    assign o_Parity_Err = perr_reg;
    assign o_Frame_Err  = ferr_reg;
    assign o_Busy       = (state_reg != IDLE);
    assign o_Break      = brk_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised scoreboard bench for uart_rx_cfg: frames are pushed as expected
// words when sent, and a monitor compares every DV/break pulse against them.
module tb_uart_rx_cfg;

    localparam int NB = 8;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   cpb_in = 16'd16;
    logic [1:0]    pmode = 2'd0;
    logic          two_stop = 1'b0;
    logic          rx = 1'b1;
    logic          dv;
    logic [NB-1:0] rdata;
    logic          perr;
    logic          ferr;
    logic          busy;
    logic          brk;

    uart_rx_cfg #(.DATA_BITS(NB), .DIV_W(16), .MIN_CPB(8)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Clks_Per_Bit (cpb_in),
        .i_Parity_Mode  (pmode),
        .i_Two_Stop     (two_stop),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Data      (rdata),
        .o_Parity_Err   (perr),
        .o_Frame_Err    (ferr),
        .o_Busy         (busy),
        .o_Break        (brk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        bit            perr;
        bit            ferr;
        bit            brk;
        bit            busy;
    } exp_t;

    exp_t          exp_q[$];
    int            n_total = 0;
    int            n_bad = 0;
    logic [NB-1:0] last_data = '0;
    bit            last_perr = 1'b0;
    bit            last_ferr = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (dv || brk)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word got dv=%0b brk=%0b data=%02h, none required", dv, brk, rdata);
            end else begin
                e = exp_q.pop_front();
                if (dv !== !e.brk || brk !== e.brk || rdata !== e.data ||
                    perr !== e.perr || ferr !== e.ferr || busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL rx_word got dv=%0b brk=%0b data=%02h perr=%0b ferr=%0b busy=%0b want dv=%0b brk=%0b data=%02h perr=%0b ferr=%0b busy=%0b",
                             dv, brk, rdata, perr, ferr, busy, !e.brk, e.brk, e.data, e.perr, e.ferr, e.busy);
                end else begin
                    $display("ok   rx_word brk=%0b data=%02h perr=%0b ferr=%0b busy=%0b", brk, rdata, perr, ferr, busy);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic drive_bit(input logic v, input int n, input bit spike);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rx = (spike && v && c == n / 2) ? 1'b0 : v;
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] data, input logic [1:0] pm, input bit two,
                              input int cpb, input bit par_flip, input bit stop1, input bit stop2,
                              input bit spike, input bit scramble, input int hold_low);
        int   eff;
        int   ones;
        bit   par_en;
        bit   par_bit;
        bit   last_stop;
        exp_t e;

        eff       = (cpb < 8) ? 8 : cpb;
        par_en    = (pm == 2'd1 || pm == 2'd2);
        // Parity bit that makes the total count of ones even (even mode) or odd (odd mode).
        par_bit   = (pm == 2'd2) ? ($countones(data) % 2 == 0) : ($countones(data) % 2 == 1);
        par_bit   = par_bit ^ par_flip;
        ones      = $countones(data) + int'(par_bit);
        last_stop = two ? stop2 : stop1;

        if (BRK_EN && data == '0 && (!par_en || !par_bit) && !stop1) begin
            e.brk  = 1'b1;
            e.data = last_data;
            e.perr = last_perr;
            e.ferr = last_ferr;
            e.busy = 1'b1;
        end else begin
            e.brk  = 1'b0;
            e.data = data;
            e.perr = par_en && ((pm == 2'd1) ? (ones % 2 == 1) : (ones % 2 == 0));
            e.ferr = !stop1 || (two && !stop2);
            e.busy = !last_stop;
            last_data = e.data;
            last_perr = e.perr;
            last_ferr = e.ferr;
        end
        exp_q.push_back(e);

        @(negedge clk);
        cpb_in   = 16'(cpb);
        pmode    = pm;
        two_stop = two;
        drive_bit(1'b0, eff, 1'b0);
        if (scramble) begin
            pmode    = pm ^ 2'b11;
            two_stop = ~two;
            cpb_in   = 16'(cpb + 7);
        end
        for (int b = 0; b < NB; b++) drive_bit(data[b], eff, spike);
        if (par_en) drive_bit(par_bit, eff, 1'b0);
        drive_bit(stop1, eff, 1'b0);
        if (two) drive_bit(stop2, eff, 1'b0);
        if (hold_low > 0) begin
            drive_bit(1'b0, hold_low * eff, 1'b0);
            check("held_low_busy", 32'(busy), 32'd1);
        end
        drive_bit(1'b1, 2 * eff, 1'b0);
        check("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stimulus
        bit saw_busy;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {26'd0, dv, brk, perr, ferr, busy, |rdata}, 32'd0);

        // 8N1 at 434 clocks per bit.
        send_frame(8'hA5, 2'd0, 1'b0, 434, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // 8E1 with a wrong then a right parity bit.
        send_frame(8'h03, 2'd1, 1'b0, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h03, 2'd1, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // 8O2, second stop low, line held low afterwards.
        send_frame(8'(($urandom_range(1, 255))), 2'd2, 1'b1, 16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        send_frame(8'h96, 2'd2, 1'b1, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Short low glitch on an idle line.
        cpb_in   = 16'd16;
        pmode    = 2'd0;
        two_stop = 1'b0;
        saw_busy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rx = 1'b0;
            if (busy) saw_busy = 1'b1;
        end
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rx = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_started", 32'(saw_busy), 32'd1);
        check("glitch_back_idle", 32'(busy), 32'd0);
        drive_bit(1'b1, 32, 1'b0);

        // Reset pulse while receiving data bits.
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b1, 16, 1'b0);
        drive_bit(1'b0, 16, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_frame", {26'd0, dv, brk, perr, ferr, busy, |rdata}, 32'd0);
        last_data = '0;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        drive_bit(1'b1, 32, 1'b0);
        send_frame(8'h5A, 2'd0, 1'b0, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        // Single-cycle low spikes inside high data bits.
        send_frame(8'hF7, 2'd1, 1'b0, 12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        // Line low for 12 bit times: break or zero word with framing error.
        send_frame(8'h00, 2'd0, 1'b0, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        // Configuration changed mid-frame must not affect it; divisor below minimum is clamped.
        send_frame(8'h3C, 2'd1, 1'b0, 12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'hC3, 2'd3, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            send_frame(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(3, 24), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
